seq_mult_bw: RTL and testbench
==============================

SEQ_MULT_BW -- requirements
Module: seq_mult_bw

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 start_valid  input  1  operand set a/b/signed_mode offered.
REQ-005 start_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 signed_mode  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-009 result_valid  output  1  product holds a completed result.
REQ-010 result_ready  input  1  consumer accepts product.
REQ-011 product  output  2*WIDTH  result of a*b.

Function
REQ-012 FSM states SHALL be IDLE, BUSY, DONE; reset state IDLE.
REQ-013 start_ready SHALL be 1 only in IDLE; result_valid SHALL be 1 only in DONE.
REQ-014 Accept: start_valid&&start_ready at an edge SHALL latch a, b, signed_mode, clear accumulator and row counter, and enter BUSY.
REQ-015 In BUSY, one partial-product row per cycle: row j = (a AND b[j]) shifted left j, added into a 2*WIDTH accumulator; counter runs 0..WIDTH-1.
REQ-016 Signed mode SHALL use Baugh-Wooley per-bit toggling: bit a[i]&b[j] inverted when exactly one of i, j equals WIDTH-1; constant 1 added at bit WIDTH and bit 2*WIDTH-1; unsigned mode: no inversion, no constants.
REQ-017 On the edge where counter = WIDTH-1 the FSM SHALL enter DONE and load product from the final accumulator value.
REQ-018 Latency: result_valid SHALL rise exactly WIDTH edges after the accepting edge.
REQ-019 product SHALL equal a*b modulo 2^(2*WIDTH), interpreted per latched signed_mode; exact for all operand pairs.
REQ-020 DONE SHALL hold product and result_valid stable until result_valid&&result_ready, then return to IDLE on that edge.
REQ-021 product SHALL retain its last value after the DONE->IDLE handshake until the next DONE load.
REQ-022 start_valid in BUSY or DONE SHALL be ignored; changes to a, b, signed_mode after accept SHALL not affect the result.
REQ-023 No overlap: a new operand set SHALL not be accepted in the same edge as result handoff; earliest next accept is the cycle after return to IDLE.

Reset
REQ-024 reset SHALL dominate all other inputs at the same edge.
REQ-025 After reset: state IDLE, start_ready 1, result_valid 0, product 0, accumulator 0, counter 0, latched operands 0.
REQ-026 reset in BUSY or DONE SHALL abort the operation with no result emitted.

Structure
REQ-027 Shared package mult_pkg SHALL hold the state enum type (IDLE, BUSY, DONE) and the WIDTH range limits.
REQ-028 One sub-module, pp_row_xor, SHALL form a WIDTH-bit partial-product row with a per-bit toggle mask (AND then XOR); the accumulator adder remains in seq_mult_bw.
REQ-029 Counter width SHALL be $clog2(WIDTH) bits, minimum 1.

Verification
REQ-030 WIDTH=8, unsigned, a=255, b=255 -> product 0xFE01, result_valid exactly 8 edges after accept.
REQ-031 WIDTH=8, signed, a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x7F -> 0xC080; a=0xFF, b=0x01 -> 0xFFFF.
REQ-032 Backpressure: result_ready held 0 for 20 cycles in DONE -> product and result_valid stable, start_valid pulses ignored, IDLE on first ready.
REQ-033 Reset asserted in BUSY row 3 -> next cycle IDLE, product 0, result_valid 0, no result emitted.
REQ-034 Operands and signed_mode toggled every cycle during BUSY -> result matches the values latched at accept.
REQ-035 Random sweep WIDTH in {2,8,16}, both modes, with random start_valid/result_ready -> every product matches reference model; back-to-back transactions with no lost or duplicated results.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the Baugh-Wooley sequential multiplier.
package mult_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Signed rows invert bits where exactly one of the bit index and row index is the MSB.
    function automatic logic [WIDTH_MAX-1:0] bw_toggle_mask(
        input int unsigned width,
        input int unsigned row,
        input logic        signed_mode
    );
        logic [WIDTH_MAX-1:0] m;
        m = '0;
        if (signed_mode) begin
            for (int unsigned i = 0; i < width; i++) begin
                if ((i == width - 1) != (row == width - 1)) begin
                    m[i] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_mult_bw_if.sv
// Operand/result handshake bundle for seq_mult_bw.
interface seq_mult_bw_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 start_valid;
    logic                 start_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 result_valid;
    logic                 result_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start_valid, a, b, signed_mode, result_ready,
        input  start_ready, result_valid, product
    );

    modport slave (
        input  start_valid, a, b, signed_mode, result_ready,
        output start_ready, result_valid, product
    );
endinterface

// File: rtl/pp_row_xor.sv
// One partial-product row: operand gated by a multiplier bit, then toggled by a mask.
module pp_row_xor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic             b_bit,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] row
);
    always_comb begin
        row = (a & {WIDTH{b_bit}}) ^ mask;
    end
endmodule

// File: rtl/seq_mult_bw.sv
// Sequential shift-add multiplier, one row per cycle; signed mode uses Baugh-Wooley correction.
module seq_mult_bw
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    seq_mult_bw_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned PW    = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    product_q, product_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             start_ready_q, start_ready_d;
    logic             result_valid_q, result_valid_d;

    logic [WIDTH-1:0] row_mask, row;
    logic [PW-1:0]    row_ext, bw_const, acc_sum;
    logic             b_bit;

    always_comb begin
        b_bit    = b_q[cnt_q];
        row_mask = WIDTH'(bw_toggle_mask(WIDTH, 32'(cnt_q), sgn_q));
    end

    pp_row_xor #(.WIDTH(WIDTH)) u_pp_row (
        .a     (a_q),
        .b_bit (b_bit),
        .mask  (row_mask),
        .row   (row)
    );

    // Both correction constants ride along with row 0 so the sum is complete at the last row.
    always_comb begin
        bw_const = '0;
        if (sgn_q && (cnt_q == '0)) begin
            bw_const[WIDTH]  = 1'b1;
            bw_const[PW-1]   = 1'b1;
        end
        row_ext = PW'(row) << cnt_q;
        acc_sum = acc_q + row_ext + bw_const;
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start_valid && start_ready_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sgn_d   = bus.signed_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                acc_d = acc_sum;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = acc_sum;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (result_valid_q && bus.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        start_ready_d  = (state_d == IDLE);
        result_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            sgn_q          <= 1'b0;
            acc_q          <= '0;
            cnt_q          <= '0;
            product_q      <= '0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            sgn_q          <= sgn_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            product_q      <= product_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.product      = product_q;

endmodule

// File: tb/tb_seq_mult_bw.sv
// Directed and swept checks of seq_mult_bw at WIDTH 8, 2 and 16.
module tb_seq_mult_bw;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    seq_mult_bw_if #(.WIDTH(8))  m8  ();
    seq_mult_bw_if #(.WIDTH(2))  m2  ();
    seq_mult_bw_if #(.WIDTH(16)) m16 ();

    seq_mult_bw #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(m8));
    seq_mult_bw #(.WIDTH(2))  u_dut2  (.clk(clk), .reset(reset), .bus(m2));
    seq_mult_bw #(.WIDTH(16)) u_dut16 (.clk(clk), .reset(reset), .bus(m16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] p;
    } vec8_t;

    vec8_t vec8 [10];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full WIDTH=8 transaction; optional operand scrambling and start_valid noise during BUSY/DONE.
    task automatic xact8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                         input logic [15:0] exp, input int unsigned hold,
                         input bit noisy, input string tag);
        int lat;
        @(negedge clk);
        m8.a = av; m8.b = bv; m8.signed_mode = s; m8.start_valid = 1'b1;
        check({tag, " start_ready"}, m8.start_ready, 1);
        @(negedge clk);
        m8.start_valid = noisy;
        check({tag, " busy"}, m8.start_ready, 0);
        lat = 0;
        while (!m8.result_valid && lat < 40) begin
            if (noisy) begin
                m8.a = 8'($urandom); m8.b = 8'($urandom); m8.signed_mode = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, lat, 8);
        check({tag, " product"}, m8.product, exp);
        for (int i = 0; i < int'(hold); i++) begin
            m8.a = 8'($urandom); m8.b = 8'($urandom); m8.start_valid = 1'($urandom);
            @(negedge clk);
            check($sformatf("%s hold%0d valid", tag, i), m8.result_valid, 1);
            check($sformatf("%s hold%0d product", tag, i), m8.product, exp);
        end
        m8.result_ready = 1'b1;
        @(negedge clk);
        m8.result_ready = 1'b0;
        m8.start_valid  = 1'b0;
        check({tag, " handoff valid"}, m8.result_valid, 0);
        check({tag, " handoff idle"}, m8.start_ready, 1);
        check({tag, " retained"}, m8.product, exp);
    endtask

    task automatic xact2(input logic [1:0] av, input logic [1:0] bv, input logic s,
                         input int unsigned pre, input int unsigned hold);
        int lat;
        longint pa, pb, pr;
        repeat (pre) @(negedge clk);
        m2.a = av; m2.b = bv; m2.signed_mode = s; m2.start_valid = 1'b1;
        check("w2 start_ready", m2.start_ready, 1);
        @(negedge clk);
        m2.start_valid = 1'b0;
        lat = 0;
        while (!m2.result_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("w2 latency", lat, 2);
        pa = s ? longint'($signed(av)) : longint'(av);
        pb = s ? longint'($signed(bv)) : longint'(bv);
        pr = pa * pb;
        check($sformatf("w2 %0h*%0h s%0d", av, bv, s), m2.product, 64'(pr[3:0]));
        repeat (hold) @(negedge clk);
        m2.result_ready = 1'b1;
        @(negedge clk);
        m2.result_ready = 1'b0;
        check("w2 handoff", m2.result_valid, 0);
    endtask

    task automatic xact16(input logic [15:0] av, input logic [15:0] bv, input logic s,
                          input int unsigned pre, input int unsigned hold);
        int lat;
        longint pa, pb, pr;
        repeat (pre) @(negedge clk);
        m16.a = av; m16.b = bv; m16.signed_mode = s; m16.start_valid = 1'b1;
        check("w16 start_ready", m16.start_ready, 1);
        @(negedge clk);
        m16.start_valid = 1'b0;
        lat = 0;
        while (!m16.result_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("w16 latency", lat, 16);
        pa = s ? longint'($signed(av)) : longint'(av);
        pb = s ? longint'($signed(bv)) : longint'(bv);
        pr = pa * pb;
        check($sformatf("w16 %0h*%0h s%0d", av, bv, s), m16.product, 64'(pr[31:0]));
        repeat (hold) @(negedge clk);
        m16.result_ready = 1'b1;
        @(negedge clk);
        m16.result_ready = 1'b0;
        check("w16 handoff", m16.result_valid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int seen;
        n_tests = 0;
        n_fail  = 0;
        vec8[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vec8[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vec8[2] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vec8[3] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vec8[4] = '{8'h80, 8'h7F, 1'b0, 16'h3F80};
        vec8[5] = '{8'h0D, 8'h0B, 1'b0, 16'h008F};
        vec8[6] = '{8'hF6, 8'h0C, 1'b1, 16'hFF88};
        vec8[7] = '{8'h00, 8'hAB, 1'b1, 16'h0000};
        vec8[8] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vec8[9] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};

        m8.start_valid = 0;  m8.a = '0;  m8.b = '0;  m8.signed_mode = 0;  m8.result_ready = 0;
        m2.start_valid = 0;  m2.a = '0;  m2.b = '0;  m2.signed_mode = 0;  m2.result_ready = 0;
        m16.start_valid = 0; m16.a = '0; m16.b = '0; m16.signed_mode = 0; m16.result_ready = 0;

        reset = 1'b1;
        m8.start_valid = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        m8.start_valid = 1'b0;
        check("reset start_ready", m8.start_ready, 1);
        check("reset result_valid", m8.result_valid, 0);
        check("reset product", m8.product, 0);
        check("reset w16 product", m16.product, 0);

        foreach (vec8[i])
            xact8(vec8[i].a, vec8[i].b, vec8[i].s, vec8[i].p, 0, 1'b0, $sformatf("vec%0d", i));

        xact8(8'h83, 8'h05, 1'b1, 16'hFD8F, 0, 1'b1, "scramble");
        xact8(8'h12, 8'h34, 1'b0, 16'h03A8, 20, 1'b1, "backpressure");

        @(negedge clk);
        m8.a = 8'h55; m8.b = 8'h0F; m8.signed_mode = 1'b0; m8.start_valid = 1'b1;
        @(negedge clk);
        m8.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        m8.start_valid  = 1'b1;
        m8.result_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m8.start_valid  = 1'b0;
        m8.result_ready = 1'b0;
        check("abort idle", m8.start_ready, 1);
        check("abort result_valid", m8.result_valid, 0);
        check("abort product", m8.product, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (m8.result_valid) seen++;
        end
        check("abort no result", seen, 0);
        xact8(8'h0F, 8'h11, 1'b0, 16'h00FF, 0, 1'b0, "after abort");

        for (int s = 0; s < 2; s++)
            for (int av = 0; av < 4; av++)
                for (int bv = 0; bv < 4; bv++)
                    xact2(2'(av), 2'(bv), 1'(s), $urandom_range(0, 2), $urandom_range(0, 3));

        xact16(16'hFFFF, 16'hFFFF, 1'b0, 0, 0);
        xact16(16'h8000, 16'h8000, 1'b1, 0, 0);
        xact16(16'h8000, 16'h7FFF, 1'b1, 0, 0);
        for (int k = 0; k < 30; k++)
            xact16(16'($urandom), 16'($urandom), 1'(k % 2), $urandom_range(0, 2), $urandom_range(0, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
